vc_plane_buffer: RTL and testbench

//  Per-port virtual-channel input buffer. Consumes the time-multiplexed plane index from the VC plane controller.

---
 rtl/vc_plane_buffer.sv | 139 +++++++++++++
 tb/tb_vc_plane_buffer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_plane_buffer.sv
// vc_plane_buffer: per-port virtual-channel input buffer.
// One FIFO per VC plane; head of the selected plane goes to the switch stage.
module vc_plane_buffer #(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VC:0]           plane_sel,
  input  logic                  in_valid,
  input  logic [VC:0]           in_vc,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [VC:0]           out_vc,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [VC-1:0]         vc_empty,
  output logic [VC-1:0]         vc_full,
  output logic                  err_bad_vc
);

  localparam int IW = (VC > 1) ? $clog2(VC) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [VC:0]   VC_L   = (VC+1)'(VC);
  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [VC][DEPTH];

  logic [PW-1:0] wr_q  [VC];
  logic [PW-1:0] wr_d  [VC];
  logic [PW-1:0] rd_q  [VC];
  logic [PW-1:0] rd_d  [VC];
  logic [CW-1:0] cnt_q [VC];
  logic [CW-1:0] cnt_d [VC];

  logic err_q;
  logic err_d;

  logic          in_ok;
  logic          sel_ok;
  logic [IW-1:0] in_idx;
  logic [IW-1:0] sel_idx;
  logic          push;
  logic          pop;
  logic [VC-1:0] push_vec;
  logic [VC-1:0] pop_vec;

  // Index decode: out-of-range indices never touch any FIFO.
  always_comb begin
    in_ok   = (in_vc < VC_L);
    sel_ok  = (plane_sel < VC_L);
    in_idx  = in_vc[IW-1:0];
    sel_idx = plane_sel[IW-1:0];
  end

  // Per-plane status flags straight from the occupancy counts.
  always_comb begin
    vc_empty = '0;
    vc_full  = '0;
    for (int v = 0; v < VC; v++) begin
      vc_empty[v] = (cnt_q[v] == '0);
      vc_full[v]  = (cnt_q[v] == FULL_L);
    end
  end

  // Handshakes; a full plane refuses even if it is popped this cycle.
  always_comb begin
    in_ready  = in_ok && !vc_full[in_idx];
    out_valid = sel_ok && !vc_empty[sel_idx];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Head of the selected plane, forced to zero when nothing is presented.
  always_comb begin
    out_vc   = plane_sel;
    out_data = '0;
    if (out_valid) begin
      out_data = mem_q[sel_idx][rd_q[sel_idx]];
    end
  end

  // One-hot push/pop strobes per plane.
  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    if (push) begin
      push_vec[in_idx] = 1'b1;
    end
    if (pop) begin
      pop_vec[sel_idx] = 1'b1;
    end
  end

  // Next pointer/count state; pointers wrap naturally modulo DEPTH.
  always_comb begin
    for (int v = 0; v < VC; v++) begin
      wr_d[v]  = wr_q[v] + PW'(push_vec[v]);
      rd_d[v]  = rd_q[v] + PW'(pop_vec[v]);
      cnt_d[v] = cnt_q[v]
               + CW'(push_vec[v])
               - CW'(pop_vec[v]);
    end
    err_d = err_q | (in_valid & ~in_ok);
  end

  // Pointer, count and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC; v++) begin
        wr_q[v]  <= '0;
        rd_q[v]  <= '0;
        cnt_q[v] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < VC; v++) begin
        wr_q[v]  <= wr_d[v];
        rd_q[v]  <= rd_d[v];
        cnt_q[v] <= cnt_d[v];
      end
      err_q <= err_d;
    end
  end

  // Flit storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[in_idx][wr_q[in_idx]] <= in_data;
    end
  end

  assign err_bad_vc = err_q;

endmodule

// File: tb/tb_vc_plane_buffer.sv
// tb_vc_plane_buffer: directed self-checking bench for vc_plane_buffer.
// Each task drives one scenario and checks inline against hand values.
module tb_vc_plane_buffer;

  logic        clk;
  logic        rst;
  logic [4:0]  plane_sel;
  logic        in_valid;
  logic [4:0]  in_vc;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_vc;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  vc_empty;
  logic [3:0]  vc_full;
  logic        err_bad_vc;

  int n_checks;
  int n_fail;

  vc_plane_buffer #(.VC(4), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .plane_sel(plane_sel),
    .in_valid(in_valid),
    .in_vc(in_vc),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_vc(out_vc),
    .out_data(out_data),
    .out_ready(out_ready),
    .vc_empty(vc_empty),
    .vc_full(vc_full),
    .err_bad_vc(err_bad_vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] vc, input logic [31:0] d);
    in_valid = 1'b1;
    in_vc    = vc;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (vc_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_empty got %h want f", vc_empty);
    end
    n_checks++;
    if (vc_full !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_full got %h want 0", vc_full);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out got %b/%h want 0/0", out_valid, out_data);
    end
    n_checks++;
    if (err_bad_vc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b want 0", err_bad_vc);
    end
  endtask

  task automatic test_single();
    plane_sel = 5'd2;
    in_valid  = 1'b1;
    in_vc     = 5'd2;
    in_data   = 32'hA5;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_bypass got %b want 0", out_valid);
    end
    step();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
      n_fail++;
      $display("FAIL single_head got %b/%h want 1/a5", out_valid, out_data);
    end
    n_checks++;
    if (out_vc !== 5'd2) begin
      n_fail++;
      $display("FAIL single_out_vc got %0d want 2", out_vc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (vc_empty[2] !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL single_pop got e=%b v=%b d=%h want 1/0/0",
               vc_empty[2], out_valid, out_data);
    end
  endtask

  task automatic test_full();
    plane_sel = 5'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(5'd0, 32'h10 + i);
    n_checks++;
    if (vc_full !== 4'b0001) begin
      n_fail++;
      $display("FAIL full_flag got %b want 0001", vc_full);
    end
    in_valid = 1'b1;
    in_vc    = 5'd0;
    in_data  = 32'hFF;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready got %b want 0", in_ready);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h10 + i) begin
        n_fail++;
        $display("FAIL full_order[%0d] got %b/%h want 1/%h",
                 i, out_valid, out_data, 32'h10 + i);
      end
      step();
    end
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (vc_empty[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drained got %b want 1", vc_empty[0]);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] sched [6];
    int cnt;
    int sent;
    int recv;
    int cyc;
    logic exp_rdy;
    logic exp_ov;
    sched[0] = 5'd0; sched[1] = 5'd0; sched[2] = 5'd0;
    sched[3] = 5'd1; sched[4] = 5'd2; sched[5] = 5'd3;
    cnt  = 0;
    sent = 0;
    recv = 0;
    cyc  = 0;
    out_ready = 1'b1;
    in_vc     = 5'd3;
    while (recv < 10 && cyc < 200) begin
      plane_sel = sched[cyc % 6];
      in_valid  = (sent < 10);
      in_data   = 32'h300 + sent;
      #1;
      exp_rdy = (cnt < 4);
      exp_ov  = (plane_sel == 5'd3) && (cnt > 0);
      n_checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_ov) begin
        n_fail++;
        $display("FAIL wrap_hs cyc %0d got r=%b v=%b want r=%b v=%b",
                 cyc, in_ready, out_valid, exp_rdy, exp_ov);
      end
      if (exp_ov) begin
        n_checks++;
        if (out_data !== 32'h300 + recv) begin
          n_fail++;
          $display("FAIL wrap_data got %h want %h", out_data, 32'h300 + recv);
        end
      end
      if (in_valid && exp_rdy) begin
        cnt++;
        sent++;
      end
      if (exp_ov) begin
        cnt--;
        recv++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (recv != 10 || vc_empty[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_done got recv=%0d e=%b want 10/1", recv, vc_empty[3]);
    end
  endtask

  task automatic test_concurrency();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(5'd1, 32'h40 + i);
    plane_sel = 5'd1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vc     = 5'd1;
    in_data   = 32'h4F;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_full got r=%b v=%b want 0/1", in_ready, out_valid);
    end
    step();
    n_checks++;
    if (vc_full[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL conc_count3 got full=%b want 0", vc_full[1]);
    end
    in_vc   = 5'd0;
    in_data = 32'h50;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_data !== 32'h41) begin
      n_fail++;
      $display("FAIL conc_split got r=%b d=%h want 1/41", in_ready, out_data);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plane_sel = 5'd0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h50) begin
      n_fail++;
      $display("FAIL conc_vc0 got %b/%h want 1/50", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    plane_sel = 5'd1;
    for (int i = 2; i < 4; i++) begin
      #1;
      n_checks++;
      if (out_data !== 32'h40 + i) begin
        n_fail++;
        $display("FAIL conc_drain got %h want %h", out_data, 32'h40 + i);
      end
      step();
    end
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (vc_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL conc_empty got %b want 1111", vc_empty);
    end
  endtask

  task automatic test_bad_index();
    push(5'd0, 32'h77);
    in_valid = 1'b1;
    in_vc    = 5'd4;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || err_bad_vc !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_vc4 got r=%b e=%b want 0/0", in_ready, err_bad_vc);
    end
    in_vc = 5'd5;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_vc5 got r=%b want 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (err_bad_vc !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_err_set got %b want 1", err_bad_vc);
    end
    step();
    step();
    n_checks++;
    if (err_bad_vc !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_err_sticky got %b want 1", err_bad_vc);
    end
    plane_sel = 5'd4;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL bad_sel got %b/%h want 0/0", out_valid, out_data);
    end
    step();
    out_ready = 1'b0;
    plane_sel = 5'd0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      n_fail++;
      $display("FAIL bad_no_pop got %b/%h want 1/77", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    push(5'd1, 32'hB0);
    push(5'd1, 32'hB1);
    plane_sel = 5'd1;
    #1;
    n_checks++;
    if (vc_empty !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_pre got %b want 1100", vc_empty);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (vc_empty !== 4'hF || out_valid !== 1'b0 || err_bad_vc !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got e=%b v=%b err=%b want 1111/0/0",
               vc_empty, out_valid, err_bad_vc);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (vc_empty !== 4'hF || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_after got e=%b d=%h want 1111/0", vc_empty, out_data);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    plane_sel = '0;
    in_valid  = 1'b0;
    in_vc     = '0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_concurrency();
    test_bad_index();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
